// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with optional two-entry skid buffer.
// Payload is an opaque WIDTH-bit vector; flush and reset both zero the stored entries.
//
// state     | meaning
// ----------+-------------------------------------------------------
// EMPTY     | no entry held, out_valid low
// FULL      | one entry in out_data
// SKID_FULL | two entries: older in out_data, younger in skid_data
module pipe_stage_skid #(
   parameter int WIDTH = 80,
   parameter bit SKID  = 1'b1
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       occupancy
);

   typedef enum logic [1:0] {
      EMPTY     = 2'd0,
      FULL      = 2'd1,
      SKID_FULL = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] skid_data, out_data_nxt, skid_data_nxt;

   // Skid mode decodes in_ready from the state flops only, cutting the out_ready path.
   assign in_ready  = SKID ? (state != SKID_FULL) : ((state == EMPTY) | out_ready);
   assign out_valid = (state != EMPTY);
   assign occupancy = state;

   always_comb begin
      state_nxt     = state;
      out_data_nxt  = out_data;
      skid_data_nxt = skid_data;
      case (state)
         EMPTY: begin
            if (in_valid) begin
               out_data_nxt = in_data;
               state_nxt    = FULL;
            end
         end
         FULL: begin
            if (in_valid && in_ready) begin
               if (out_ready) begin
                  out_data_nxt = in_data;
               end else if (SKID) begin
                  skid_data_nxt = in_data;
                  state_nxt     = SKID_FULL;
               end
            end else if (out_ready) begin
               state_nxt = EMPTY;
            end
         end
         SKID_FULL: begin
            if (out_ready) begin
               out_data_nxt = skid_data;
               state_nxt    = FULL;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      // Zeroing keeps stale control fields from reaching downstream decode.
      if (flush) begin
         state_nxt     = EMPTY;
         out_data_nxt  = '0;
         skid_data_nxt = '0;
      end
   end

   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         state     <= EMPTY;
         out_data  <= '0;
         skid_data <= '0;
      end else begin
         state     <= state_nxt;
         out_data  <= out_data_nxt;
         skid_data <= skid_data_nxt;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks of pipe_stage_skid in skid (u1) and single-entry (u0) modes.
module tb_pipe_stage_skid;

   logic        clk = 1'b0;
   logic        clrn;
   logic        fl1, iv1, or1, in_ready1, out_valid1;
   logic [15:0] id1, out_data1;
   logic [1:0]  occ1;
   logic        fl0, iv0, or0, in_ready0, out_valid0;
   logic [15:0] id0, out_data0;
   logic [1:0]  occ0;

   int total = 0;
   int passed = 0;
   int fails = 0;
   logic [15:0] q1[$];
   logic [15:0] q0[$];
   logic tk1_in, tk1_out, tk0_in, tk0_out;

   always #5 clk = ~clk;

   pipe_stage_skid #(.WIDTH(16), .SKID(1'b1)) u1 (
      .clk(clk), .clrn(clrn), .flush(fl1), .in_valid(iv1), .in_data(id1),
      .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
      .out_ready(or1), .occupancy(occ1)
   );

   pipe_stage_skid #(.WIDTH(16), .SKID(1'b0)) u0 (
      .clk(clk), .clrn(clrn), .flush(fl0), .in_valid(iv0), .in_data(id0),
      .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
      .out_ready(or0), .occupancy(occ0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic rdy, input logic vld,
                       input logic [15:0] dat, input logic [1:0] occ);
      chk({tag, "_in_ready1"}, 32'(in_ready1), 32'(rdy));
      chk({tag, "_valid1"}, 32'(out_valid1), 32'(vld));
      chk({tag, "_data1"}, 32'(out_data1), 32'(dat));
      chk({tag, "_occ1"}, 32'(occ1), 32'(occ));
   endtask

   initial begin
      clrn = 1'b1;
      fl1 = 0; iv1 = 0; or1 = 0; id1 = '0;
      fl0 = 0; iv0 = 0; or0 = 0; id0 = '0;
      #2;
      chk1("reset", 1'b1, 1'b0, 16'h0, 2'd0);
      chk("reset_in_ready0", 32'(in_ready0), 32'd1);
      chk("reset_valid0", 32'(out_valid0), 32'd0);
      chk("reset_occ0", 32'(occ0), 32'd0);
      step();
      clrn = 1'b0;

      // streaming, skid mode
      or1 = 1'b1; iv1 = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         id1 = 16'(i);
         step();
         chk1($sformatf("stream%0d", i), 1'b1, 1'b1, 16'(i), 2'd1);
      end
      iv1 = 1'b0;
      step();
      chk("stream_drain_occ1", 32'(occ1), 32'd0);
      chk("stream_drain_valid1", 32'(out_valid1), 32'd0);

      // back-pressure, skid mode
      iv1 = 1'b1; id1 = 16'hA; or1 = 1'b1;
      step();
      chk1("bp_a", 1'b1, 1'b1, 16'hA, 2'd1);
      id1 = 16'hB; or1 = 1'b0;
      step();
      chk1("bp_skid", 1'b0, 1'b1, 16'hA, 2'd2);
      id1 = 16'hC;
      step();
      chk1("bp_hold1", 1'b0, 1'b1, 16'hA, 2'd2);
      step();
      chk1("bp_hold2", 1'b0, 1'b1, 16'hA, 2'd2);
      or1 = 1'b1;
      #1;
      chk("bp_ready_registered", 32'(in_ready1), 32'd0);
      step();
      chk1("bp_b", 1'b1, 1'b1, 16'hB, 2'd1);
      step();
      chk1("bp_c", 1'b1, 1'b1, 16'hC, 2'd1);
      iv1 = 1'b0;
      step();
      chk("bp_empty_occ1", 32'(occ1), 32'd0);

      // flush in SKID_FULL with a payload offered
      iv1 = 1'b1; id1 = 16'h11; or1 = 1'b1;
      step();
      id1 = 16'h22; or1 = 1'b0;
      step();
      chk1("fl_pre", 1'b0, 1'b1, 16'h11, 2'd2);
      fl1 = 1'b1; id1 = 16'h55;
      step();
      chk1("fl_post", 1'b1, 1'b0, 16'h0, 2'd0);
      fl1 = 1'b0; iv1 = 1'b0;
      step();
      chk1("fl_no55", 1'b1, 1'b0, 16'h0, 2'd0);

      // flush against a full load+drain handshake
      iv1 = 1'b1; id1 = 16'h33; or1 = 1'b1;
      step();
      fl1 = 1'b1; id1 = 16'h44;
      step();
      chk1("fl_hs", 1'b1, 1'b0, 16'h0, 2'd0);
      fl1 = 1'b0; iv1 = 1'b0;

      // asynchronous reset with two entries held
      id1 = 16'h66; iv1 = 1'b1; or1 = 1'b1;
      step();
      id1 = 16'h77; or1 = 1'b0;
      step();
      chk1("rst_pre", 1'b0, 1'b1, 16'h66, 2'd2);
      clrn = 1'b1;
      #1;
      chk1("rst_async", 1'b1, 1'b0, 16'h0, 2'd0);
      iv1 = 1'b0;
      step();
      clrn = 1'b0;

      // single-entry mode
      iv0 = 1'b1; id0 = 16'h21; or0 = 1'b0;
      #1;
      chk("se_empty_ready", 32'(in_ready0), 32'd1);
      step();
      id0 = 16'h31;
      #1;
      chk("se_full_ready", 32'(in_ready0), 32'd0);
      chk("se_full_data", 32'(out_data0), 32'h21);
      chk("se_full_occ", 32'(occ0), 32'd1);
      step();
      chk("se_stall_data", 32'(out_data0), 32'h21);
      or0 = 1'b1;
      #1;
      chk("se_comb_ready", 32'(in_ready0), 32'd1);
      step();
      chk("se_ld_drain_data", 32'(out_data0), 32'h31);
      chk("se_ld_drain_occ", 32'(occ0), 32'd1);
      iv0 = 1'b0;
      step();
      chk("se_empty_occ", 32'(occ0), 32'd0);
      chk("se_empty_valid", 32'(out_valid0), 32'd0);

      // randomized traffic against a queue scoreboard
      fl1 = 1'b1; fl0 = 1'b1;
      step();
      q1.delete(); q0.delete();
      for (int n = 0; n < 3000; n++) begin
         iv1 = ($urandom_range(0, 3) != 0);
         or1 = ($urandom_range(0, 3) != 0);
         fl1 = ($urandom_range(0, 31) == 0);
         id1 = 16'($urandom);
         iv0 = ($urandom_range(0, 3) != 0);
         or0 = ($urandom_range(0, 3) != 0);
         fl0 = ($urandom_range(0, 31) == 0);
         id0 = 16'($urandom);
         #1;
         chk("r1_in_ready", 32'(in_ready1), 32'(q1.size() < 2));
         chk("r1_valid", 32'(out_valid1), 32'(q1.size() != 0));
         chk("r1_occ", 32'(occ1), 32'(q1.size()));
         if (q1.size() != 0) chk("r1_data", 32'(out_data1), 32'(q1[0]));
         chk("r0_in_ready", 32'(in_ready0), 32'((q0.size() == 0) || or0));
         chk("r0_valid", 32'(out_valid0), 32'(q0.size() != 0));
         chk("r0_occ", 32'(occ0), 32'(q0.size()));
         if (q0.size() != 0) chk("r0_data", 32'(out_data0), 32'(q0[0]));
         tk1_in  = iv1 && (q1.size() < 2);
         tk1_out = (q1.size() != 0) && or1;
         tk0_in  = iv0 && ((q0.size() == 0) || or0);
         tk0_out = (q0.size() != 0) && or0;
         @(posedge clk);
         if (fl1) q1.delete();
         else begin
            if (tk1_out) void'(q1.pop_front());
            if (tk1_in) q1.push_back(id1);
         end
         if (fl0) q0.delete();
         else begin
            if (tk0_out) void'(q0.pop_front());
            if (tk0_in) q0.push_back(id0);
         end
         #1;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
